// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, instruction field
// positions and the default reset fetch address.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'b01,
        ST_ISSUE = 2'b10
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int OP_MSB    = 27;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 25;
    localparam int FUNCT_LSB = 20;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 12;

    // Word-align an address; fetch addresses never carry low bits.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_instr_split.sv
// Combinational extraction of the decode fields from a registered instruction word.
module instr_split
    import fetch_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  cond_o,
    output logic [1:0]  op_o,
    output logic [5:0]  funct_o,
    output logic [3:0]  rd_o
);

    assign cond_o  = instr_i[COND_MSB:COND_LSB];
    assign op_o    = instr_i[OP_MSB:OP_LSB];
    assign funct_o = instr_i[FUNCT_MSB:FUNCT_LSB];
    assign rd_o    = instr_i[RD_MSB:RD_LSB];

    // Bits not used by this split stay visible to later decode stages via instr.
    logic unused_bits;
    assign unused_bits = ^{instr_i[FUNCT_LSB-1:RD_MSB+1], instr_i[RD_LSB-1:0]};

endmodule

// File: rtl/fetch_stage.sv
// Two-state instruction fetch: request a word, then hold it until downstream
// consumes it, optionally redirecting the next fetch.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [3:0]  cond,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rd,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus8,
    output logic [15:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [15:0]  count_q, count_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_REQ;
            pc_q     <= align_pc(RESET_PC);
            instr_q  <= '0;
            valid_q  <= 1'b0;
            pc_out_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            pc_out_q <= pc_out_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        pc_out_d = pc_out_q;
        count_d  = count_q;
        case (state_q)
            ST_REQ: begin
                if (imem_ready) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    valid_d  = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A stalled consumer freezes everything, including any redirect.
                if (!stall) begin
                    valid_d = 1'b0;
                    count_d = count_q + 16'd1;
                    if (pc_src) begin
                        pc_d = align_pc(branch_target);
                    end
                    state_d = ST_REQ;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_REQ;
            end
        endcase
    end

    // Gating with reset makes the request drop in the same cycle reset asserts.
    assign imem_req    = reset && (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_plus8    = pc_out_q + 32'd8;
    assign fetch_count = count_q;

    instr_split u_split (
        .instr_i (instr_q),
        .cond_o  (cond),
        .op_o    (op),
        .funct_o (funct),
        .rd_o    (rd)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations plus a randomized run compared cycle by cycle with a model.
module tb_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [31:0] pc_out;
    logic [31:0] pc_plus8;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;
    logic run_cmp = 1'b0;

    fetch_stage #(.RESET_PC(TB_RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .cond          (cond),
        .op            (op),
        .funct         (funct),
        .rd            (rd),
        .pc_out        (pc_out),
        .pc_plus8      (pc_plus8),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: either waiting for a word (not holding) or holding one.
    logic [31:0] m_pc;
    logic        m_hold;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;
    logic [15:0] m_count;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc    <= TB_RESET_PC;
            m_hold  <= 1'b0;
            m_instr <= 32'h0;
            m_pcout <= 32'h0;
            m_count <= 16'h0;
        end else if (!m_hold) begin
            if (imem_ready) begin
                m_instr <= imem_rdata;
                m_pcout <= m_pc;
                m_pc    <= m_pc + 32'd4;
                m_hold  <= 1'b1;
            end
        end else if (!stall) begin
            m_hold  <= 1'b0;
            m_count <= m_count + 16'd1;
            if (pc_src) m_pc <= branch_target & 32'hFFFF_FFFC;
            $display("txn %0d: pc=%08h instr=%08h next=%08h", m_count + 16'd1, m_pcout, m_instr,
                     pc_src ? (branch_target & 32'hFFFF_FFFC) : m_pc);
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("cmp_req",   {31'b0, imem_req},    {31'b0, reset && !m_hold});
            check("cmp_addr",  imem_addr,            m_pc);
            check("cmp_valid", {31'b0, instr_valid}, {31'b0, m_hold});
            check("cmp_instr", instr,                m_instr);
            check("cmp_cond",  {28'b0, cond},        {28'b0, m_instr[31:28]});
            check("cmp_op",    {30'b0, op},          {30'b0, m_instr[27:26]});
            check("cmp_funct", {26'b0, funct},       {26'b0, m_instr[25:20]});
            check("cmp_rd",    {28'b0, rd},          {28'b0, m_instr[15:12]});
            check("cmp_pcout", pc_out,               m_pcout);
            check("cmp_pc8",   pc_plus8,             m_pcout + 32'd8);
            check("cmp_count", {16'b0, fetch_count}, {16'b0, m_count});
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] word;
        reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; pc_src = 1'b0; branch_target = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        run_cmp = 1'b1;
        check("rst_req",   {31'b0, imem_req},    32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_count", {16'b0, fetch_count}, 32'h0);
        check("rst_instr", instr,                32'h0);

        // Release: first fetch at RESET_PC straight away.
        reset = 1'b1;
        #1;
        check("first_req",  {31'b0, imem_req}, 32'h1);
        check("first_addr", imem_addr,         TB_RESET_PC);

        // Back-to-back fetches, memory always ready.
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", imem_addr, 32'(4 * i));
            word = $urandom;
            imem_rdata = word;
            next_cycle();
            check("seq_valid_hi", {31'b0, instr_valid}, 32'h1);
            check("seq_instr",    instr,                word);
            check("seq_pcout",    pc_out,               32'(4 * i));
            next_cycle();
            check("seq_valid_lo", {31'b0, instr_valid}, 32'h0);
            check("seq_count",    {16'b0, fetch_count}, 32'(i + 1));
        end

        // Slow memory at 0x10: address held until ready.
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("wait_addr", imem_addr,         32'h10);
            check("wait_req",  {31'b0, imem_req}, 32'h1);
            next_cycle();
        end
        check("wait_addr4", imem_addr, 32'h10);
        imem_ready = 1'b1;
        word = 32'hA5A5_0F0F;
        imem_rdata = word;
        next_cycle();
        check("late_valid", {31'b0, instr_valid}, 32'h1);

        // Stall with a pending redirect: nothing moves.
        imem_ready = 1'b0;
        stall = 1'b1; pc_src = 1'b1; branch_target = 32'h0000_0103;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            check("stall_valid", {31'b0, instr_valid}, 32'h1);
            check("stall_req",   {31'b0, imem_req},    32'h0);
            check("stall_instr", instr,                word);
            check("stall_pcout", pc_out,               32'h10);
            check("stall_addr",  imem_addr,            32'h14);
        end
        stall = 1'b0;
        next_cycle();
        check("redir_addr",  imem_addr,            32'h100);
        check("redir_req",   {31'b0, imem_req},    32'h1);
        check("redir_count", {16'b0, fetch_count}, 32'h5);

        // Redirect to the top word, then check address wrap.
        imem_ready = 1'b1; imem_rdata = $urandom;
        branch_target = 32'hFFFF_FFFF;
        next_cycle();
        next_cycle();
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        pc_src = 1'b0;
        imem_rdata = 32'hE081_2003;
        next_cycle();
        check("top_pcout", pc_out,         32'hFFFF_FFFC);
        check("top_pc8",   pc_plus8,       32'h0000_0004);
        check("fld_cond",  {28'b0, cond},  32'hE);
        check("fld_op",    {30'b0, op},    32'h0);
        check("fld_funct", {26'b0, funct}, 32'h08);
        check("fld_rd",    {28'b0, rd},    32'h2);
        next_cycle();
        check("wrap_addr", imem_addr, 32'h0);

        // Reset in the middle of a pending request.
        imem_ready = 1'b0;
        next_cycle();
        reset = 1'b0;
        imem_ready = 1'b1;
        #1;
        check("mid_rst_req", {31'b0, imem_req}, 32'h0);
        next_cycle();
        imem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("post_rst_addr",  imem_addr,            TB_RESET_PC);
        check("post_rst_valid", {31'b0, instr_valid}, 32'h0);
        check("post_rst_count", {16'b0, fetch_count}, 32'h0);
        check("post_rst_req",   {31'b0, imem_req},    32'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            imem_ready    = ($urandom_range(0, 3) != 0);
            stall         = ($urandom_range(0, 3) == 0);
            pc_src        = ($urandom_range(0, 2) == 0);
            branch_target = $urandom;
            imem_rdata    = $urandom;
            reset         = ($urandom_range(0, 199) != 0);
            next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        run_cmp = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
